// File: rtl/instr_fetch_if.sv
// ----------------------------------------------------------------------------
// instr_fetch_if
//   Groups the instruction-bus handshake and the fetch/decode handoff of the
//   fetch stage into one bundle.
//
//   Instruction bus (fetch drives the request, memory drives the response):
//     ireq_valid     read request valid
//     ireq_addr      request address (current PC)
//     iresp_addr_ok  request accepted this cycle
//     iresp_data_ok  read data returned this cycle
//     iresp_data     returned instruction word
//   Decode side:
//     branch         redirect strobe from decode
//     PCbranch       redirect target, meaningful while branch=1
//     dataD_ready    decode accepts dataF this cycle
//     dataF_valid    fetched instruction valid
//     dataF_pc       PC of fetched instruction
//     dataF_instr    raw instruction word
//     fetch_cnt      number of completed dataF handshakes
//
//   Modports: master = fetch stage, slave = bus/decode environment.
// ----------------------------------------------------------------------------
interface instr_fetch_if #(
    parameter int unsigned CNT_W = 64
);
    logic             ireq_valid;
    logic [63:0]      ireq_addr;
    logic             iresp_addr_ok;
    logic             iresp_data_ok;
    logic [31:0]      iresp_data;
    logic             branch;
    logic [63:0]      PCbranch;
    logic             dataD_ready;
    logic             dataF_valid;
    logic [63:0]      dataF_pc;
    logic [31:0]      dataF_instr;
    logic [CNT_W-1:0] fetch_cnt;

    modport master (
        output ireq_valid, ireq_addr,
        input  iresp_addr_ok, iresp_data_ok, iresp_data,
        input  branch, PCbranch, dataD_ready,
        output dataF_valid, dataF_pc, dataF_instr, fetch_cnt
    );

    modport slave (
        input  ireq_valid, ireq_addr,
        output iresp_addr_ok, iresp_data_ok, iresp_data,
        output branch, PCbranch, dataD_ready,
        input  dataF_valid, dataF_pc, dataF_instr, fetch_cnt
    );
endinterface

// File: rtl/instr_fetch.sv
// ----------------------------------------------------------------------------
// instr_fetch
//   Fetch stage. Owns the PC, issues one instruction read at a time on the
//   instruction bus and presents {valid, pc, instr} to decode through a single
//   output register backed by one hold slot. A decode redirect flushes the
//   output register and hold slot; a read already on the bus when the redirect
//   arrives is marked with a kill flag and its data is discarded on return.
//
//   Ports:
//     clk    rising-edge clock
//     reset  asynchronous, active-low reset
//     fif    instr_fetch_if.master: ibus request/response, decode redirect,
//            decode ready, dataF outputs and the handshake counter
//
//   Parameters:
//     PC_RESET  first PC fetched after reset
//     CNT_W     width of fetch_cnt (wraps)
// ----------------------------------------------------------------------------
module instr_fetch #(
    parameter logic [63:0] PC_RESET = 64'h8000_0000,
    parameter int unsigned CNT_W    = 64
) (
    input  logic          clk,
    input  logic          reset,
    instr_fetch_if.master fif
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_HOLD
    } state_e;

    state_e           state_q, state_d;
    logic [63:0]      pc_q, pc_d;
    logic             kill_q, kill_d;
    logic [63:0]      target_q, target_d;
    logic             out_valid_q, out_valid_d;
    logic [63:0]      out_pc_q, out_pc_d;
    logic [31:0]      out_instr_q, out_instr_d;
    logic [31:0]      hold_instr_q, hold_instr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic handshake;
    logic out_free;
    logic complete;

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            pc_q         <= PC_RESET;
            kill_q       <= 1'b0;
            target_q     <= '0;
            out_valid_q  <= 1'b0;
            out_pc_q     <= '0;
            out_instr_q  <= '0;
            hold_instr_q <= '0;
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            kill_q       <= kill_d;
            target_q     <= target_d;
            out_valid_q  <= out_valid_d;
            out_pc_q     <= out_pc_d;
            out_instr_q  <= out_instr_d;
            hold_instr_q <= hold_instr_d;
            cnt_q        <= cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        kill_d       = kill_q;
        target_d     = target_q;
        out_valid_d  = out_valid_q;
        out_pc_d     = out_pc_q;
        out_instr_d  = out_instr_q;
        hold_instr_d = hold_instr_q;
        complete     = 1'b0;

        handshake = out_valid_q & fif.dataD_ready;
        // The output register can take a new word if it is empty or its
        // current word leaves this cycle.
        out_free  = ~out_valid_q | fif.dataD_ready;

        if (handshake) begin
            out_valid_d = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                state_d = S_REQ;
                if (fif.branch) begin
                    pc_d = fif.PCbranch;
                end
            end

            S_REQ: begin
                if (fif.iresp_addr_ok && fif.iresp_data_ok) begin
                    complete = 1'b1;
                end else begin
                    if (fif.iresp_addr_ok) begin
                        state_d = S_WAIT;
                    end
                    // Without addr_ok the request must stay on the bus
                    // unchanged, so the redirect is deferred via kill.
                    if (fif.branch) begin
                        kill_d   = 1'b1;
                        target_d = fif.PCbranch;
                    end
                end
            end

            S_WAIT: begin
                if (fif.iresp_data_ok) begin
                    complete = 1'b1;
                end else if (fif.branch) begin
                    kill_d   = 1'b1;
                    target_d = fif.PCbranch;
                end
            end

            S_HOLD: begin
                if (fif.branch) begin
                    pc_d    = fif.PCbranch;
                    state_d = S_REQ;
                end else if (out_free) begin
                    // Parked word belongs to pc_q; PC only advances here.
                    out_valid_d = 1'b1;
                    out_pc_d    = pc_q;
                    out_instr_d = hold_instr_q;
                    pc_d        = pc_q + 64'd4;
                    state_d     = S_REQ;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Read completion: a redirect arriving with the data takes priority
        // over a pending kill, which takes priority over delivery.
        if (complete) begin
            state_d = S_REQ;
            kill_d  = 1'b0;
            if (fif.branch) begin
                pc_d = fif.PCbranch;
            end else if (kill_q) begin
                pc_d = target_q;
            end else if (out_free) begin
                out_valid_d = 1'b1;
                out_pc_d    = pc_q;
                out_instr_d = fif.iresp_data;
                pc_d        = pc_q + 64'd4;
            end else begin
                hold_instr_d = fif.iresp_data;
                state_d      = S_HOLD;
            end
        end

        if (fif.branch) begin
            out_valid_d = 1'b0;
        end

        cnt_d = cnt_q + CNT_W'(handshake);
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    always_comb begin
        fif.ireq_valid  = (state_q == S_REQ);
        fif.ireq_addr   = (state_q == S_REQ) ? pc_q : '0;
        fif.dataF_valid = out_valid_q;
        fif.dataF_pc    = out_pc_q;
        fif.dataF_instr = out_instr_q;
        fif.fetch_cnt   = cnt_q;
    end

endmodule

// File: tb/tb_instr_fetch.sv
// ----------------------------------------------------------------------------
// tb_instr_fetch
//   Directed table of cycle vectors, hand-written redirect/reset sequences and
//   a randomized run scored against an instruction-stream reference model.
// ----------------------------------------------------------------------------
module tb_instr_fetch;

    localparam logic [63:0] B = 64'h8000_0000;
    localparam logic [63:0] W = 64'hFFFF_FFFF_FFFF_FFFC;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    instr_fetch_if #(.CNT_W(64)) fif();

    instr_fetch #(
        .PC_RESET(B),
        .CNT_W(64)
    ) dut (
        .clk(clk),
        .reset(reset),
        .fif(fif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory image: each word is a function of its address.
    function automatic logic [31:0] mem_word(input logic [63:0] a);
        return a[31:0] ^ a[63:32] ^ 32'h5A5A_0013;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic expect_out(input string name, input logic rv, input logic [63:0] ra,
                              input logic fv, input logic [63:0] fpc, input logic [63:0] cnt);
        check({name, "/ireq_valid"}, {63'd0, fif.ireq_valid}, {63'd0, rv});
        check({name, "/ireq_addr"}, fif.ireq_addr, ra);
        check({name, "/dataF_valid"}, {63'd0, fif.dataF_valid}, {63'd0, fv});
        check({name, "/fetch_cnt"}, fif.fetch_cnt, cnt);
        if (fv) begin
            check({name, "/dataF_pc"}, fif.dataF_pc, fpc);
            check({name, "/dataF_instr"}, {32'd0, fif.dataF_instr}, {32'd0, mem_word(fpc)});
        end
    endtask

    task automatic step(input logic aok, input logic dok, input logic [31:0] data,
                        input logic br, input logic [63:0] tgt, input logic rdy);
        fif.iresp_addr_ok = aok;
        fif.iresp_data_ok = dok;
        fif.iresp_data    = data;
        fif.branch        = br;
        fif.PCbranch      = tgt;
        fif.dataD_ready   = rdy;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        step(1'b0, 1'b0, '0, 1'b0, '0, 1'b1);
        reset = 1'b0;
        step(1'b0, 1'b0, '0, 1'b0, '0, 1'b1);
        step(1'b0, 1'b0, '0, 1'b0, '0, 1'b1);
        reset = 1'b1;
    endtask

    typedef struct {
        logic        aok;
        logic        dok;
        logic        rdy;
        logic [63:0] daddr;
        logic        exp_rv;
        logic [63:0] exp_ra;
        logic        exp_fv;
        logic [63:0] exp_fpc;
        logic [63:0] exp_cnt;
    } vec_t;

    vec_t tbl[17];

    // Watchdog
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected finish");
        $fatal(1);
    end

    initial begin
        // Zero-wait stream, delayed addr_ok, decode stall with hold slot.
        //             aok   dok   rdy   daddr     rv    ra        fv    fpc       cnt
        tbl[0]  = '{1'b0, 1'b0, 1'b1, 64'd0,     1'b0, 64'd0,    1'b0, 64'd0,    64'd0};
        tbl[1]  = '{1'b1, 1'b1, 1'b1, B,         1'b1, B,        1'b0, 64'd0,    64'd0};
        tbl[2]  = '{1'b1, 1'b1, 1'b1, B+4,       1'b1, B+4,      1'b1, B,        64'd0};
        tbl[3]  = '{1'b1, 1'b1, 1'b1, B+8,       1'b1, B+8,      1'b1, B+4,      64'd1};
        tbl[4]  = '{1'b0, 1'b0, 1'b1, 64'd0,     1'b1, B+'hC,    1'b1, B+8,      64'd2};
        tbl[5]  = '{1'b0, 1'b0, 1'b1, 64'd0,     1'b1, B+'hC,    1'b0, 64'd0,    64'd3};
        tbl[6]  = '{1'b0, 1'b0, 1'b1, 64'd0,     1'b1, B+'hC,    1'b0, 64'd0,    64'd3};
        tbl[7]  = '{1'b1, 1'b0, 1'b1, 64'd0,     1'b1, B+'hC,    1'b0, 64'd0,    64'd3};
        tbl[8]  = '{1'b0, 1'b1, 1'b1, B+'hC,     1'b0, 64'd0,    1'b0, 64'd0,    64'd3};
        tbl[9]  = '{1'b1, 1'b1, 1'b0, B+'h10,    1'b1, B+'h10,   1'b1, B+'hC,    64'd3};
        tbl[10] = '{1'b0, 1'b0, 1'b0, 64'd0,     1'b0, 64'd0,    1'b1, B+'hC,    64'd3};
        tbl[11] = '{1'b0, 1'b0, 1'b0, 64'd0,     1'b0, 64'd0,    1'b1, B+'hC,    64'd3};
        tbl[12] = '{1'b0, 1'b0, 1'b0, 64'd0,     1'b0, 64'd0,    1'b1, B+'hC,    64'd3};
        tbl[13] = '{1'b0, 1'b0, 1'b0, 64'd0,     1'b0, 64'd0,    1'b1, B+'hC,    64'd3};
        tbl[14] = '{1'b0, 1'b0, 1'b1, 64'd0,     1'b0, 64'd0,    1'b1, B+'hC,    64'd3};
        tbl[15] = '{1'b0, 1'b0, 1'b1, 64'd0,     1'b1, B+'h14,   1'b1, B+'h10,   64'd4};
        tbl[16] = '{1'b0, 1'b0, 1'b1, 64'd0,     1'b1, B+'h14,   1'b0, 64'd0,    64'd5};

        checks = 0;
        errors = 0;
        reset  = 1'b0;
        fif.iresp_addr_ok = 1'b0;
        fif.iresp_data_ok = 1'b0;
        fif.iresp_data    = '0;
        fif.branch        = 1'b0;
        fif.PCbranch      = '0;
        fif.dataD_ready   = 1'b1;

        // Reset state
        step(1'b0, 1'b0, '0, 1'b0, '0, 1'b1);
        step(1'b0, 1'b0, '0, 1'b0, '0, 1'b1);
        expect_out("reset", 1'b0, 64'd0, 1'b0, 64'd0, 64'd0);
        check("reset/dataF_pc", fif.dataF_pc, 64'd0);
        check("reset/dataF_instr", {32'd0, fif.dataF_instr}, 64'd0);
        reset = 1'b1;

        for (int i = 0; i < 17; i++) begin
            expect_out($sformatf("tbl%0d", i), tbl[i].exp_rv, tbl[i].exp_ra,
                       tbl[i].exp_fv, tbl[i].exp_fpc, tbl[i].exp_cnt);
            step(tbl[i].aok, tbl[i].dok, mem_word(tbl[i].daddr), 1'b0, '0, tbl[i].rdy);
        end

        // Redirect while waiting for data: returning word dropped.
        step(1'b1, 1'b0, '0, 1'b0, '0, 1'b1);
        expect_out("brwait_a", 1'b0, 64'd0, 1'b0, 64'd0, 64'd5);
        step(1'b0, 1'b0, '0, 1'b1, B+'h100, 1'b1);
        expect_out("brwait_b", 1'b0, 64'd0, 1'b0, 64'd0, 64'd5);
        step(1'b0, 1'b1, mem_word(B+'h14), 1'b0, '0, 1'b1);
        expect_out("brwait_c", 1'b1, B+'h100, 1'b0, 64'd0, 64'd5);
        step(1'b1, 1'b1, mem_word(B+'h100), 1'b0, '0, 1'b1);
        expect_out("brwait_d", 1'b1, B+'h104, 1'b1, B+'h100, 64'd5);

        // Redirect coinciding with data_ok, then two redirects while killed.
        step(1'b1, 1'b0, '0, 1'b0, '0, 1'b1);
        expect_out("brdata_a", 1'b0, 64'd0, 1'b0, 64'd0, 64'd6);
        step(1'b0, 1'b1, mem_word(B+'h104), 1'b1, B+'h200, 1'b1);
        expect_out("brdata_b", 1'b1, B+'h200, 1'b0, 64'd0, 64'd6);
        step(1'b1, 1'b0, '0, 1'b0, '0, 1'b1);
        step(1'b0, 1'b0, '0, 1'b1, B+'h300, 1'b1);
        step(1'b0, 1'b0, '0, 1'b1, B+'h400, 1'b1);
        expect_out("br2_a", 1'b0, 64'd0, 1'b0, 64'd0, 64'd6);
        step(1'b0, 1'b1, mem_word(B+'h200), 1'b0, '0, 1'b1);
        expect_out("br2_b", 1'b1, B+'h400, 1'b0, 64'd0, 64'd6);
        step(1'b1, 1'b1, mem_word(B+'h400), 1'b0, '0, 1'b1);
        expect_out("br2_c", 1'b1, B+'h404, 1'b1, B+'h400, 64'd6);

        // Redirect in S_REQ without addr_ok keeps the request; target then wraps.
        step(1'b0, 1'b0, '0, 1'b1, W, 1'b1);
        expect_out("wrap_a", 1'b1, B+'h404, 1'b0, 64'd0, 64'd7);
        step(1'b1, 1'b1, mem_word(B+'h404), 1'b0, '0, 1'b1);
        expect_out("wrap_b", 1'b1, W, 1'b0, 64'd0, 64'd7);
        step(1'b1, 1'b1, mem_word(W), 1'b0, '0, 1'b1);
        expect_out("wrap_c", 1'b1, 64'd0, 1'b1, W, 64'd7);

        // Reset asserted during S_WAIT; late data_ok ignored.
        step(1'b1, 1'b0, '0, 1'b0, '0, 1'b1);
        expect_out("rst_a", 1'b0, 64'd0, 1'b0, 64'd0, 64'd8);
        #2;
        reset = 1'b0;
        #1;
        expect_out("rst_b", 1'b0, 64'd0, 1'b0, 64'd0, 64'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        step(1'b0, 1'b1, mem_word(W), 1'b0, '0, 1'b1);
        expect_out("rst_c", 1'b1, B, 1'b0, 64'd0, 64'd0);
        step(1'b1, 1'b1, mem_word(B), 1'b0, '0, 1'b1);
        expect_out("rst_d", 1'b1, B+4, 1'b1, B, 64'd0);

        // Randomized run against an instruction-stream model.
        begin
            logic [63:0] exp_pc;
            logic [63:0] model_cnt;
            logic        outstanding;
            logic [63:0] out_addr;
            logic        prev_stall;
            logic [63:0] prev_addr;
            logic        prev_branch;
            int          hs_total;
            logic        aok, dok, br, rdy;
            logic [63:0] tgt;
            logic [31:0] data;

            do_reset();
            exp_pc      = B;
            model_cnt   = '0;
            outstanding = 1'b0;
            out_addr    = '0;
            prev_stall  = 1'b0;
            prev_addr   = '0;
            prev_branch = 1'b0;
            hs_total    = 0;

            for (int cyc = 0; cyc < 4000; cyc++) begin
                if (prev_stall) begin
                    check("rnd/req_held_valid", {63'd0, fif.ireq_valid}, 64'd1);
                    check("rnd/req_held_addr", fif.ireq_addr, prev_addr);
                end
                if (prev_branch) begin
                    check("rnd/flush_after_branch", {63'd0, fif.dataF_valid}, 64'd0);
                end
                check("rnd/fetch_cnt", fif.fetch_cnt, model_cnt);

                rdy = ($urandom_range(0, 3) != 0);
                br  = ($urandom_range(0, 9) == 0);
                if ($urandom_range(0, 7) == 0) begin
                    tgt = 64'hFFFF_FFFF_FFFF_FFF8;
                end else begin
                    tgt = {32'd0, 32'h8000_0000 | ($urandom & 32'h0000_FFFC)};
                end
                aok  = fif.ireq_valid && !outstanding && ($urandom_range(0, 1) == 1);
                dok  = 1'b0;
                data = $urandom;
                if (outstanding) begin
                    dok  = ($urandom_range(0, 2) == 0);
                    data = mem_word(out_addr);
                end else if (aok) begin
                    dok  = ($urandom_range(0, 1) == 1);
                    data = mem_word(fif.ireq_addr);
                end

                if (fif.dataF_valid && rdy) begin
                    check("rnd/dataF_pc", fif.dataF_pc, exp_pc);
                    check("rnd/dataF_instr", {32'd0, fif.dataF_instr}, {32'd0, mem_word(fif.dataF_pc)});
                    exp_pc    = fif.dataF_pc + 64'd4;
                    model_cnt = model_cnt + 64'd1;
                    hs_total++;
                end
                if (br) begin
                    exp_pc = tgt;
                end

                if (aok && !dok) begin
                    outstanding = 1'b1;
                    out_addr    = fif.ireq_addr;
                end
                if (dok) begin
                    outstanding = 1'b0;
                end
                prev_stall  = fif.ireq_valid && !aok;
                prev_addr   = fif.ireq_addr;
                prev_branch = br;

                step(aok, dok, data, br, tgt, rdy);
            end
            check("rnd/progress", {63'd0, hs_total >= 100}, 64'd1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
